register_file: RTL

- 16 x 32-bit ARM general register file. Sits directly downstream of the 4-to-16 write-select decoder and consumes its 16-bit one-hot output as per-register load enables.
- Provides three combinational read ports: A and B for operands, D for the store-data source.
- R15 is the program counter. Besides the decoder write, it has a dedicated update path from fetch.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/reg32.sv | 28 ++
 rtl/register_file.sv | 107 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the 16 x 32-bit ARM register file.
package regfile_pkg;

    localparam int NUM_REGS = 16;
    localparam int REG_W    = 32;
    localparam int PC_IDX   = 15;

    typedef logic [REG_W-1:0] reg_word_t;
    typedef logic [3:0]       reg_idx_t;

    // True when two or more select bits are set (clearing the lowest set bit leaves something).
    function automatic logic sel_multi_hot(input logic [NUM_REGS-1:0] sel);
        logic [NUM_REGS-1:0] one;
        one = {{(NUM_REGS-1){1'b0}}, 1'b1};
        return (sel & (sel - one)) != '0;
    endfunction

endpackage

// File: rtl/reg32.sv
// Single DATA_W-bit register with synchronous reset value and load enable.
module reg32
    import regfile_pkg::*;
#(
    parameter int                DATA_W  = REG_W,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_le,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    // Reset wins over load so a write in flight during reset is dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= RST_VAL;
        end else if (i_le) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/register_file.sv
// 16 x 32-bit ARM general register file with three combinational read ports.
// R15 is the PC: it also loads from fetch (PC_IN/PC_LE) when no decoder
// write targets it. SEL_ERR latches any multi-hot LOAD_SEL until reset.
// Optional build macro REGFILE_BYPASS_EN: read ports forward the data being
// written this cycle instead of the stored value. PC_OUT is never bypassed.
module register_file
    import regfile_pkg::*;
#(
    parameter int                DATA_W   = REG_W,
    parameter logic [DATA_W-1:0] PC_RESET = '0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NUM_REGS-1:0] LOAD_SEL,
    input  logic [DATA_W-1:0]   PW,
    input  logic [3:0]          RA,
    input  logic [3:0]          RB,
    input  logic [3:0]          RD,
    output logic [DATA_W-1:0]   PA,
    output logic [DATA_W-1:0]   PB,
    output logic [DATA_W-1:0]   PD,
    input  logic [DATA_W-1:0]   PC_IN,
    input  logic                PC_LE,
    output logic [DATA_W-1:0]   PC_OUT,
    output logic                SEL_ERR
);

    logic [DATA_W-1:0]   w_q [NUM_REGS];
    logic [NUM_REGS-1:0] w_le;
    logic                w_multi_hot;
    logic                w_one_hot;
    logic                w_pc_from_pw;
    logic [DATA_W-1:0]   w_pc_d;
    logic                r_sel_err;

    assign w_multi_hot  = sel_multi_hot(LOAD_SEL);
    assign w_one_hot    = (LOAD_SEL != '0) && !w_multi_hot;

    // A decoder write to R15 is a branch and beats the sequential fetch update.
    assign w_pc_from_pw = w_one_hot & LOAD_SEL[PC_IDX];
    assign w_pc_d       = w_pc_from_pw ? PW : PC_IN;

    for (genvar g = 0; g < PC_IDX; g++) begin : g_gpr
        assign w_le[g] = w_one_hot & LOAD_SEL[g];

        reg32 #(
            .DATA_W  (DATA_W),
            .RST_VAL ('0)
        ) u_reg (
            .i_clk (CLK),
            .i_rst (RST),
            .i_le  (w_le[g]),
            .i_d   (PW),
            .o_q   (w_q[g])
        );
    end

    // Fetch updates are still honoured when LOAD_SEL is multi-hot.
    assign w_le[PC_IDX] = w_pc_from_pw | PC_LE;

    reg32 #(
        .DATA_W  (DATA_W),
        .RST_VAL (PC_RESET)
    ) u_pc (
        .i_clk (CLK),
        .i_rst (RST),
        .i_le  (w_le[PC_IDX]),
        .i_d   (w_pc_d),
        .o_q   (w_q[PC_IDX])
    );

    // Sticky select-error flag, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sel_err <= 1'b0;
        end else if (w_multi_hot) begin
            r_sel_err <= 1'b1;
        end
    end

    assign SEL_ERR = r_sel_err;
    assign PC_OUT  = w_q[PC_IDX];

`ifdef REGFILE_BYPASS_EN
    // Forward whatever the selected register is about to load this edge.
    // For R15 that is PC_IN whenever the fetch path, not PW, is the source.
    function automatic logic [DATA_W-1:0] read_port(input reg_idx_t sel);
        logic [DATA_W-1:0] v;
        v = w_q[sel];
        if (w_one_hot && LOAD_SEL[sel]) begin
            v = PW;
        end else if ((sel == reg_idx_t'(PC_IDX)) && PC_LE) begin
            v = PC_IN;
        end
        return v;
    endfunction

    assign PA = read_port(RA);
    assign PB = read_port(RB);
    assign PD = read_port(RD);
`else
    assign PA = w_q[RA];
    assign PB = w_q[RB];
    assign PD = w_q[RD];
`endif

endmodule
